// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: default reset PC, NOP encoding,
// fetch FSM state encoding and the IF/ID bundle layout.
package mips_pkg;

    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef enum logic {
        FETCH = 1'b0,
        HOLD  = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic        adel;
    } ifid_t;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: loads the fetched bundle when load=1, else holds.
// Ports: clk, reset_n (async active-low), load, d (next bundle), q (bundle in D).
module ifid_reg
    import mips_pkg::*;
(
    input  logic  clk,
    input  logic  reset_n,
    input  logic  load,
    input  ifid_t d,
    output ifid_t q
);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.pc    <= 32'h0;
            q.instr <= NOP_INSTR;
            q.valid <= 1'b0;
            q.adel  <= 1'b0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: F-stage PC, variable-latency imem request,
// one-entry stall buffer and the IF/ID register. Optional macro: FETCH_ADEL_EN
// (misaligned PC raises a fetch address error instead of issuing a request).
// Ports: clk, reset_n | npc, stall | imem_req/addr/rdata/ack |
//        pc_f, pc_d, instr_d, valid_d, fetch_wait, adel_d.
module fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] npc,
    input  logic        stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    input  logic        imem_ack,
    output logic [31:0] pc_f,
    output logic [31:0] pc_d,
    output logic [31:0] instr_d,
    output logic        valid_d,
    output logic        fetch_wait,
    output logic        adel_d
);

`ifdef FETCH_ADEL_EN
    localparam logic ADEL_EN = 1'b1;
`else
    localparam logic ADEL_EN = 1'b0;
`endif

    fetch_state_e state, next_state;

    logic [31:0] buffer;
    logic        buf_adel;
    logic        adel_f;
    logic        ack_f;
    logic [31:0] data_f;
    logic        load;
    logic        buf_we;
    ifid_t       ifid_d;
    ifid_t       ifid_q;

`ifdef FETCH_ADEL_EN
    assign adel_f = (pc_f[1:0] != 2'b00);
`else
    assign adel_f = 1'b0;
`endif

    // A misaligned fetch never reaches memory; it completes at once as a NOP.
    assign ack_f  = adel_f | imem_ack;
    assign data_f = adel_f ? NOP_INSTR : imem_rdata;

    // Gated with reset_n so an abandoned request drops while in reset.
    assign imem_req  = reset_n & (state == FETCH) & ~adel_f;
    assign imem_addr = {pc_f[31:2], 2'b00};

    always_comb begin
        next_state   = state;
        load         = 1'b0;
        buf_we       = 1'b0;
        fetch_wait   = 1'b0;
        ifid_d.pc    = pc_f;
        ifid_d.instr = buffer;
        ifid_d.valid = 1'b1;
        ifid_d.adel  = buf_adel;
        unique case (state)
            FETCH: begin
                ifid_d.instr = data_f;
                ifid_d.adel  = adel_f;
                fetch_wait   = ~ack_f;
                if (ack_f) begin
                    if (stall) begin
                        buf_we     = 1'b1;
                        next_state = HOLD;
                    end else begin
                        load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (!stall) begin
                    load       = 1'b1;
                    next_state = FETCH;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= FETCH;
            pc_f     <= RESET_PC;
            buffer   <= NOP_INSTR;
            buf_adel <= 1'b0;
        end else begin
            state <= next_state;
            if (load) begin
                pc_f <= npc;
            end
            if (buf_we) begin
                buffer   <= data_f;
                buf_adel <= adel_f;
            end
        end
    end

    ifid_reg u_ifid (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (load),
        .d       (ifid_d),
        .q       (ifid_q)
    );

    assign pc_d    = ifid_q.pc;
    assign instr_d = ifid_q.instr;
    assign valid_d = ifid_q.valid;
    assign adel_d  = ifid_q.adel & ADEL_EN;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: expected D-stage stream from a program
// model, randomized memory latency and stalls, monitor checking each cycle.
module tb_fetch_unit;

`ifdef FETCH_ADEL_EN
    localparam bit ADEL_ON = 1'b1;
`else
    localparam bit ADEL_ON = 1'b0;
`endif
    localparam logic [31:0] RPC = 32'h0000_3000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        adel;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] npc;
    logic        stall = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic        imem_ack = 1'b0;
    logic [31:0] pc_f;
    logic [31:0] pc_d;
    logic [31:0] instr_d;
    logic        valid_d;
    logic        fetch_wait;
    logic        adel_d;

    int   checks = 0;
    int   passed = 0;
    int   mode = 0;
    bit   run = 1'b0;
    bit   junk = 1'b0;
    exp_t exp_q[$];

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .npc        (npc),
        .stall      (stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_rdata (imem_rdata),
        .imem_ack   (imem_ack),
        .pc_f       (pc_f),
        .pc_d       (pc_d),
        .instr_d    (instr_d),
        .valid_d    (valid_d),
        .fetch_wait (fetch_wait),
        .adel_d     (adel_d)
    );

    function automatic logic [31:0] mem(input logic [31:0] a);
        return a ^ 32'h5A5A_0000;
    endfunction

    // Program flow: the address that follows pc in program order.
    function automatic logic [31:0] next_of(input logic [31:0] pc, input int m);
        logic [31:0] h;
        logic [31:0] t;
        if (m == 1) begin
            if (pc == 32'h3014) return 32'h3100;
            if (pc == 32'h3104) return 32'h3102;
            if (pc == 32'h3102) return 32'h3200;
        end
        if (m == 2) begin
            h = pc * 32'h9E37_79B1;
            if (h[31:29] == 3'd0) begin
                t = 32'h4000 + {20'h0, h[19:10], 2'b00};
                if (t == pc) t = pc + 32'd4;
                return t;
            end
        end
        return pc + 32'd4;
    endfunction

    assign npc = next_of(pc_f, mode);

    task automatic regen();
        logic [31:0] p;
        bit          mis;
        exp_t        e;
        exp_q.delete();
        p = RPC;
        for (int i = 0; i < 600; i++) begin
            mis     = ADEL_ON && (p[1:0] != 2'b00);
            e.pc    = p;
            e.instr = mis ? 32'h0 : mem({p[31:2], 2'b00});
            e.adel  = mis;
            exp_q.push_back(e);
            p = next_of(p, mode);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    function automatic int lat_of(input logic [31:0] a, input int m);
        if (m == 0 && a == 32'h3004) return 3;
        if (m == 0 && a == 32'h3020) return 20;
        if (m == 1 && a == 32'h3014) return 2;
        if (m == 2) return int'($urandom_range(0, 3));
        return 0;
    endfunction

    // Memory responder and stall driver.
    int rem = 0;
    bit busy = 1'b0;
    int stall_cnt = 0;
    int acc3008 = 0;
    always @(negedge clk) begin
        if (!reset_n) begin
            imem_ack   = junk;
            imem_rdata = 32'hFFFF_FFFF;
            busy       = 1'b0;
            stall      = 1'b0;
            stall_cnt  = 0;
        end else begin
            imem_ack = 1'b0;
            if (mode == 2) begin
                stall = ($urandom_range(0, 3) == 0);
            end else begin
                stall = (stall_cnt > 0);
                if (stall_cnt > 0) stall_cnt--;
            end
            if (imem_req) begin
                if (!busy) begin
                    busy = 1'b1;
                    rem  = lat_of(imem_addr, mode);
                end
                if (rem == 0) begin
                    imem_ack   = 1'b1;
                    imem_rdata = mem(imem_addr);
                    busy       = 1'b0;
                    if (mode == 0 && imem_addr == 32'h3008) begin
                        acc3008++;
                        stall     = 1'b1;
                        stall_cnt = 1;
                    end
                end else begin
                    rem--;
                end
            end else begin
                busy = 1'b0;
            end
        end
    end

    // Monitor: spec-level timing model plus scoreboard of the D stream.
    bit          hold_m = 1'b0;
    bit          exp_adv = 1'b0;
    logic [31:0] prev_pc = 0;
    logic [31:0] prev_in = 0;
    logic        prev_v = 0;
    logic        prev_a = 0;
    int          pops = 0;
    int          wait3004 = 0;
    logic [31:0] br_pcf = 32'hx;
    logic [31:0] mis_instr = 32'hx;
    logic        mis_adel = 1'bx;
    always @(negedge clk) begin
        exp_t d;
        exp_t e;
        bit   mis;
        bit   ereq;
        bit   eack;
        #2;
        if (!reset_n || !run) begin
            hold_m  = 1'b0;
            exp_adv = 1'b0;
            prev_pc = 32'h0;
            prev_in = 32'h0;
            prev_v  = 1'b0;
            prev_a  = 1'b0;
        end else if (exp_q.size() < 2) begin
            chk("exp_queue_depth", exp_q.size(), 2);
        end else begin
            if (exp_adv) begin
                d = exp_q.pop_front();
                pops++;
                chk("pc_d", pc_d, d.pc);
                chk("instr_d", instr_d, d.instr);
                chk("valid_d", valid_d, 1);
                chk("adel_d", adel_d, d.adel);
                if (d.pc == 32'h3014) br_pcf = pc_f;
                if (d.pc == 32'h3102) begin
                    mis_instr = instr_d;
                    mis_adel  = adel_d;
                end
            end else begin
                chk("pc_d_hold", pc_d, prev_pc);
                chk("instr_d_hold", instr_d, prev_in);
                chk("valid_d_hold", valid_d, prev_v);
                chk("adel_d_hold", adel_d, prev_a);
            end
            prev_pc = pc_d;
            prev_in = instr_d;
            prev_v  = valid_d;
            prev_a  = adel_d;
            e    = exp_q[0];
            mis  = ADEL_ON && (e.pc[1:0] != 2'b00);
            ereq = !hold_m && !mis;
            chk("pc_f", pc_f, e.pc);
            chk("imem_req", imem_req, ereq);
            if (ereq) chk("imem_addr", imem_addr, {e.pc[31:2], 2'b00});
            eack = hold_m || mis || imem_ack;
            chk("fetch_wait", fetch_wait, !hold_m && !eack);
            if (mode == 0 && fetch_wait && imem_addr == 32'h3004) wait3004++;
            exp_adv = eack && !stall;
            hold_m  = eack && stall;
        end
    end

    initial begin
        int base;
        bit found;
        mode = 0;
        regen();
        repeat (2) @(negedge clk);
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        run     = 1'b1;
        found   = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            @(negedge clk);
            #3;
            found = imem_req && (imem_addr == 32'h3020);
        end
        chk("reach_3020", found, 1);
        repeat (2) @(negedge clk);
        #3;
        reset_n = 1'b0;
        run     = 1'b0;
        #1;
        chk("rst_pc_f", pc_f, RPC);
        chk("rst_pc_d", pc_d, 0);
        chk("rst_instr_d", instr_d, 0);
        chk("rst_valid_d", valid_d, 0);
        chk("rst_adel_d", adel_d, 0);
        chk("rst_imem_req", imem_req, 0);
        junk = 1'b1;
        repeat (2) @(negedge clk);
        #3;
        chk("rst_req_ack_junk", imem_req, 0);
        chk("rst_pc_f_ack_junk", pc_f, RPC);
        chk("wait_3004_cycles", wait3004, 3);
        chk("access_3008_count", acc3008, 1);
        junk = 1'b0;
        mode = 1;
        regen();
        @(negedge clk);
        @(posedge clk);
        #3;
        base    = pops;
        reset_n = 1'b1;
        run     = 1'b1;
        chk("first_req_after_rst", imem_addr, RPC);
        repeat (40) @(negedge clk);
        #3;
        chk("branch_pc_f_after_slot", br_pcf, 32'h3100);
        chk("mis_instr_d", mis_instr, ADEL_ON ? 32'h0 : mem(32'h3100));
        chk("mis_adel_d", mis_adel, ADEL_ON);
        chk("mode1_progress", (pops - base) >= 15, 1);
        reset_n = 1'b0;
        run     = 1'b0;
        mode    = 2;
        regen();
        @(negedge clk);
        @(posedge clk);
        #3;
        base    = pops;
        reset_n = 1'b1;
        run     = 1'b1;
        repeat (400) @(negedge clk);
        #3;
        chk("random_progress", (pops - base) >= 60, 1);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage of the MIPS pipeline: owns the F-stage program counter and the IF/ID pipeline register. Each cycle it consumes the next-PC value produced by the D-stage next-PC logic, issues a request to a variable-latency instruction memory, and advances the fetched instruction into D. Stalls from the hazard unit and memory wait states are handled here. Branch delay slots are preserved and no flush is performed.

## Interface
- `RESET_PC`, 32'h0000_3000: PC value loaded on reset.
- `clk` in 1: clock; all state updates on the rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `npc` in 32: next PC from the next-PC logic; valid only while the D-stage instruction is stable.
- `stall` in 1: hazard-unit stall; holds the PC and IF/ID.
- `imem_req` out 1: fetch request.
- `imem_addr` out 32: word address of the request.
- `imem_rdata` in 32: instruction, valid when `imem_ack`=1.
- `imem_ack` in 1: instruction-memory completion; sampled only while `imem_req`=1.
- `pc_f` out 32: current fetch PC.
- `pc_d` out 32: PC of the instruction in D.
- `instr_d` out 32: instruction in D.
- `valid_d` out 1: D holds a real instruction (0 until the first fetch completes).
- `fetch_wait` out 1: fetch outstanding; the hazard unit must hold D and earlier and bubble E.
- `adel_d` out 1: instruction-fetch address error for the instruction in D (see Configuration).

## Operation
- FSM states: FETCH, HOLD.
- FETCH:
  - `imem_req`=1, `imem_addr`={pc_f[31:2],2'b00}.
  - `imem_ack`=0: PC and IF/ID hold; `fetch_wait`=1.
  - `imem_ack`=1 and `stall`=0: IF/ID <= {pc_f, imem_rdata, valid 1}; pc_f <= npc; stay in FETCH.
  - `imem_ack`=1 and `stall`=1: imem_rdata is captured into a one-entry buffer; go to HOLD.
- HOLD:
  - `imem_req`=0, `fetch_wait`=0.
  - On `stall`=0: IF/ID <= {pc_f, buffer, valid 1}; pc_f <= npc; go to FETCH.
- `npc` is sampled only on an advance edge. D is never bubbled by this unit, so a branch in D keeps `npc` correct across wait states and the delay slot is fetched normally.
- Arithmetic: none internal. `pc_f` is taken verbatim from `npc`, with no wrap checks; 32-bit rollover is passed through.
- Reset values: pc_f=RESET_PC, pc_d=0, instr_d=32'h0 (nop), valid_d=0, adel_d=0, state FETCH, buffer=0.
- Reset mid-fetch: the outstanding request is abandoned and `imem_req` drops while `reset_n`=0. Any `imem_ack` received during reset is ignored. The first request after release targets RESET_PC.

## Timing
- Zero-wait memory (ack in the request cycle): one instruction per cycle, pc_f -> pc_d latency 1 cycle.
- N wait cycles: `fetch_wait` is high for N cycles; IF/ID advances on the edge where ack arrives.
- `stall` and `imem_ack` in the same cycle: the buffer captures the instruction. Release costs no extra memory access; IF/ID loads on the first edge with `stall`=0.
- `imem_req`, `imem_addr` and `fetch_wait` are combinational from state and `pc_f`. `fetch_wait` also depends combinationally on `imem_ack`.

## Configuration
- `FETCH_ADEL_EN` defined:
  - pc_f[1:0]!=0 in FETCH: no request is issued and the fetch is treated as acked in that cycle with instruction 32'h0.
  - adel_d=1 travels with that instruction through IF/ID, including via HOLD.
- Undefined: adel_d is tied to 0 and pc_f[1:0] is ignored.

## Structure
- Shared package `mips_pkg`: RESET_PC default constant, NOP_INSTR (32'h0), and the fetch FSM state encoding.
- One sub-module, `ifid_reg`: IF/ID register with load and hold, asynchronous active-low reset, and fields pc, instr, valid, adel.

## Test plan
- Reset release with zero-wait memory returning `addr` as data, and npc=pc_f+4:
  - pc_f sequence is 3000, 3004, 3008.
  - pc_d/instr_d follow one cycle later.
  - valid_d rises one cycle after release.
- Ack delayed 3 cycles at PC 3004:
  - `fetch_wait` is high for 3 cycles.
  - pc_d stays at 3000 for those cycles.
  - pc_d becomes 3004 on the ack edge.
- `stall` high for 2 cycles coinciding with ack at PC 3008:
  - state goes to HOLD and `imem_req`=0.
  - on release, instr_d equals the buffered word and pc_f becomes npc.
  - exactly one memory access occurs for 3008.
- Branch in D at 3010 with npc=3100 during the delay slot fetch at 3014, ack delayed 2 cycles:
  - after the ack, pc_f=3100.
  - pc_d=3014.
- Reset asserted mid-wait at pc_f=3020:
  - outputs return to reset values asynchronously.
  - `imem_req` is 0 during reset.
  - the first request after release is 3000.
- With `FETCH_ADEL_EN`, npc=3002:
  - no `imem_req` is issued for 3002.
  - next cycle pc_d=3002, instr_d=0, adel_d=1.
  - without the macro, `imem_addr`=3000 and adel_d=0.
